mips_instr_loader: RTL
======================

Name: mips_instr_loader

Overview:
- Encoder counterpart to the single-cycle main decoder: accepts instruction fields over a valid/ready stream and packs them into 32-bit MIPS words.
- Uses the same opcode set the decoder recognises: RTYPE, LW, SW, BEQ, ADDI, J, ORI, BNE.
- Writes encoded words sequentially into instruction memory from a programmable base word address.
- Used by benches and boot logic to load programs before the core runs.

Parameters:
- AW, 6, instruction-memory word-address width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a load session at base_addr.
- base_addr  input  AW  first word address of the session.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader accepts a bundle this cycle.
- in_kind  input  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 ORI, 7 BNE; 8-15 illegal.
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
- in_funct  input  6  R-type function field.
- in_imm  input  16  I-type immediate.
- in_target  input  26  J-type target.
- in_last  input  1  bundle is the final instruction of the session.
- imem_stall  input  1  memory cannot take a write this cycle.
- imem_we  output  1  write strobe.
- imem_addr  output  AW  write word address.
- imem_wdata  output  32  encoded instruction.
- count  output  AW+1  words written this session.
- done  output  1  session complete (level).
- err  output  1  sticky: an illegal in_kind was received.
- wrap  output  1  sticky: write pointer wrapped past 2^AW-1.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; ptr=0; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0, wrap=0.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, ORI 001101, BNE 000101.
- Formats:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I (LW/SW/BEQ/BNE/ADDI/ORI): {op, rs, rt, imm}; unused fields ignored.
  - J: {op, target}.
- IDLE: in_ready=0; on start, ptr<=base_addr, count<=0, err<=0, wrap<=0 -> LOAD.
- LOAD: in_ready=1.
  - On in_valid&in_ready with legal kind: register the encoded word and the in_last value -> WRITE.
  - Illegal kind: bundle consumed and dropped; err<=1; stay in LOAD.
  - If the illegal bundle has in_last=1 -> DONE.
- WRITE: in_ready=0; imem_we=1, imem_addr=ptr, imem_wdata=word (registered outputs, stable while stalled).
  - If imem_stall=1: hold everything.
  - Otherwise the write commits: ptr<=ptr+1 mod 2^AW; count<=count+1.
  - If ptr was 2^AW-1, wrap<=1.
  - Next state is DONE if the registered last flag was set, else LOAD.
- DONE: done=1, in_ready=0, imem_we=0; on start, re-initialise as from IDLE (done drops the next cycle) -> LOAD.
- start is ignored in LOAD and WRITE.
- Latency and throughput: bundle accepted in cycle N; imem_we is asserted in cycle N+1; with no stall, the write commits at the end of N+1. Peak rate is one word per 2 cycles.
- count saturates at 2^AW; wrap still flags overwrite.
- Reset mid-session aborts immediately; no partial write may follow reset deassertion.

Test Plan:
- Encodings. Send each bundle and check imem_wdata, one write each:
  - ADDI rs=0 rt=8 imm=5 -> 0x20080005.
  - LW rs=0 rt=9 imm=4 -> 0x8C090004.
  - RTYPE rs=8 rt=9 rd=10 shamt=0 funct=0x20 -> 0x01095020.
  - J target=0x10 -> 0x08000010.
  - BEQ rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF.
  - ORI rs=8 rt=8 imm=0xFF -> 0x350800FF.
- Session: base_addr=4, three bundles, last bundle with in_last=1 -> writes at addresses 4,5,6; count=3; done=1; in_ready=0 afterwards.
- Stall: hold imem_stall=1 for 3 cycles during WRITE -> imem_we, addr and data stable for 4 cycles; exactly one commit; in_ready stays 0.
- Illegal kind: in_kind=9 in the middle of a session -> no write; err=1 for the rest of the session; the following legal bundle is written at the next ptr.
- Wrap (AW=6): base_addr=63, two bundles -> addresses 63 then 0; wrap=1.
- Reset: assert reset during WRITE while stalled -> outputs at reset values immediately; no imem_we after release; start restarts cleanly with err, wrap and count cleared.

Source files
------------

// File: rtl/mips_instr_loader.sv
// Packs MIPS instruction field bundles into 32-bit words and writes them
// sequentially into instruction memory starting at a programmable base address.
module mips_instr_loader #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  input  logic          in_last,
  input  logic          imem_stall,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err,
  output logic          wrap
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // LOAD  | in_ready high, waiting for a bundle
  // WRITE | imem_we high, waiting for a non-stalled cycle to commit
  // DONE  | session complete, done high until next start
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [AW:0]   CNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

  state_t        state;
  logic [AW-1:0] ptr;
  logic          last_q;
  logic [5:0]    op;
  logic          legal;
  logic [31:0]   enc;

  always_comb begin
    op    = 6'b000000;
    legal = 1'b1;
    case (in_kind)
      4'd0:    op = 6'b000000;
      4'd1:    op = 6'b100011;
      4'd2:    op = 6'b101011;
      4'd3:    op = 6'b000100;
      4'd4:    op = 6'b001000;
      4'd5:    op = 6'b000010;
      4'd6:    op = 6'b001101;
      4'd7:    op = 6'b000101;
      default: legal = 1'b0;
    endcase
    if (in_kind == 4'd0)
      enc = {op, in_rs, in_rt, in_rd, in_shamt, in_funct};
    else if (in_kind == 4'd5)
      enc = {op, in_target};
    else
      enc = {op, in_rs, in_rt, in_imm};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ptr      <= base_addr;
            count    <= '0;
            err      <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc;
              last_q     <= in_last;
              in_ready   <= 1'b0;
              state      <= WRITE;
            end else begin
              // illegal bundle is consumed without a write
              err <= 1'b1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end
            end
          end
        end
        WRITE: begin
          if (!imem_stall) begin
            imem_we <= 1'b0;
            ptr     <= ptr + 1'b1;
            if (count != CNT_MAX)
              count <= count + 1'b1;
            if (ptr == PTR_MAX)
              wrap <= 1'b1;
            if (last_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
